// File: rtl/rr_grant_arbiter_4_pkg.sv
// Shared constants for the 4-way round-robin grant arbiter.
package rr_grant_arbiter_4_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

endpackage

// File: rtl/rr_grant_arbiter_4_decoder.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module decoder_2to4 (
    input  logic       en,
    input  logic [1:0] in,
    output logic [3:0] out
);

    assign out = en ? (4'b0001 << in) : 4'b0000;

endmodule

// File: rtl/rr_grant_arbiter_4.sv
// Round-robin arbiter for 4 requesters with ownership hold and fairness timeout.
// The grant vector is decoded purely from registered state.
module rr_grant_arbiter_4
    import rr_grant_arbiter_4_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             switch
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             state, state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt;
    logic             switch_nxt;
    logic [N_REQ-1:0] others;
    logic [IDX_W:0]   pick_idle, pick_oth;

    // First set bit of r searching upward from after+1, wrapping; returns {found, idx}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] after);
        logic             found;
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        win   = after;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = after + IDX_W'(off);
            if (!found && r[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        return {found, win};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            last      <= IDX_W'(N_REQ - 1);
            hold_cnt  <= '0;
            switch    <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_idx <= idx_nxt;
            last      <= last_nxt;
            hold_cnt  <= cnt_nxt;
            switch    <= switch_nxt;
        end
    end

    // Competing requests exclude the owner so a same-cycle re-assert waits its turn.
    always_comb begin
        others     = req & ~(N_REQ'(1) << grant_idx);
        pick_idle  = rr_pick(req, last);
        pick_oth   = rr_pick(others, grant_idx);
        state_nxt  = state;
        idx_nxt    = grant_idx;
        last_nxt   = last;
        cnt_nxt    = hold_cnt;
        switch_nxt = 1'b0;
        if (state == GRANT) begin
            if (!en) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (!req[grant_idx] || ((|others) && hold_cnt == HOLD_LAST)) begin
                if (pick_oth[IDX_W]) begin
                    idx_nxt    = pick_oth[IDX_W-1:0];
                    last_nxt   = pick_oth[IDX_W-1:0];
                    cnt_nxt    = '0;
                    switch_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end else if (|others) begin
                cnt_nxt = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
            end else begin
                cnt_nxt = '0;
            end
        end else if (en && pick_idle[IDX_W]) begin
            state_nxt  = GRANT;
            idx_nxt    = pick_idle[IDX_W-1:0];
            last_nxt   = pick_idle[IDX_W-1:0];
            cnt_nxt    = '0;
            switch_nxt = 1'b1;
        end
    end

    always_comb begin
        grant_valid = (state == GRANT);
    end

    decoder_2to4 u_dec (
        .en  (grant_valid),
        .in  (grant_idx),
        .out (grant)
    );

endmodule
